potato_core: RTL and testbench

//  Multicycle RV32I-subset integer core with one shared instruction/data memory port.

---
 rtl/potato_core.sv | 210 +++++++++++++++++++++
 tb/tb_potato_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/potato_core.sv
// Multicycle RV32I-subset core sharing one memory port for fetch and data.
// Optional macro CORE_TRAP_HALT_EN: ECALL/EBREAK/illegal opcodes park the core in HALT.
module potato_core #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_read,
  output logic             mem_write
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t             state_q, state_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   regs_q [32];
  logic [WIDTH-1:0]   ir_q, rs1v_q, rs2v_q, imm_q, res_q, npc_q, mdr_q;

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [4:0]         rd_idx, rs1_idx, rs2_idx;
  logic               is_lw, is_sw, wb_en, trap, taken;
  logic [WIDTH-1:0]   imm, op_b, alu, exec_res, exec_npc;
  logic signed [WIDTH-1:0] a_s, b_s;

  assign opc     = ir_q[6:0];
  assign f3      = ir_q[14:12];
  assign rd_idx  = ir_q[11:7];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign is_lw   = (opc == OPC_LOAD)  && (f3 == 3'b010);
  assign is_sw   = (opc == OPC_STORE) && (f3 == 3'b010);
  assign wb_en   = (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
                   (opc == OPC_JALR) || (opc == OPC_OP) || (opc == OPC_OPIMM) || is_lw;

`ifdef CORE_TRAP_HALT_EN
  logic legal;
  assign legal = wb_en || is_sw || (opc == OPC_BRANCH) || (opc == 7'b0001111);
  assign trap  = !legal;
`else
  assign trap  = 1'b0;
`endif

  always_comb begin
    imm = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opc)
      OPC_STORE:            imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH:           imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:   imm = {ir_q[31:12], 12'b0};
      OPC_JAL:              imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:              imm = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // ALU shared by OP and OP-IMM; bit 30 selects SUB (OP only) and arithmetic right shift
  assign op_b = (opc == OPC_OP) ? rs2v_q : imm_q;
  assign a_s  = rs1v_q;
  assign b_s  = op_b;

  always_comb begin
    alu = '0;
    case (f3)
      3'b000: alu = ((opc == OPC_OP) && ir_q[30]) ? rs1v_q - op_b : rs1v_q + op_b;
      3'b001: alu = rs1v_q << op_b[4:0];
      3'b010: alu = {{(WIDTH-1){1'b0}}, a_s < b_s};
      3'b011: alu = {{(WIDTH-1){1'b0}}, rs1v_q < op_b};
      3'b100: alu = rs1v_q ^ op_b;
      3'b101: alu = ir_q[30] ? WIDTH'(a_s >>> op_b[4:0]) : rs1v_q >> op_b[4:0];
      3'b110: alu = rs1v_q | op_b;
      default: alu = rs1v_q & op_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = (rs1v_q == rs2v_q);
      3'b001: taken = (rs1v_q != rs2v_q);
      3'b100: taken = ($signed(rs1v_q) <  $signed(rs2v_q));
      3'b101: taken = ($signed(rs1v_q) >= $signed(rs2v_q));
      3'b110: taken = (rs1v_q <  rs2v_q);
      3'b111: taken = (rs1v_q >= rs2v_q);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_res = '0;
    exec_npc = pc_q + WIDTH'(4);
    case (opc)
      OPC_LUI:              exec_res = imm_q;
      OPC_AUIPC:            exec_res = pc_q + imm_q;
      OPC_JAL: begin
        exec_res = pc_q + WIDTH'(4);
        exec_npc = pc_q + imm_q;
      end
      OPC_JALR: begin
        exec_res = pc_q + WIDTH'(4);
        exec_npc = (rs1v_q + imm_q) & ~WIDTH'(1);
      end
      OPC_BRANCH:           if (taken) exec_npc = pc_q + imm_q;
      OPC_OP, OPC_OPIMM:    exec_res = alu;
      OPC_LOAD, OPC_STORE:  exec_res = rs1v_q + imm_q;
      default:              exec_res = '0;
    endcase
  end

  // Requests are issued one cycle after entering FETCH/MEM and dropped the cycle after mem_resp
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      FETCH: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = {pc_q[WIDTH-1:2], 2'b00};
        end else if (mem_resp) begin
          rd_d    = 1'b0;
          addr_d  = '0;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (trap)                state_d = HALT;
        else if (is_lw || is_sw) state_d = MEM;
        else                     state_d = WB;
      end
      MEM: begin
        if (!rd_q && !wr_q) begin
          rd_d    = is_lw;
          wr_d    = is_sw;
          addr_d  = {res_q[WIDTH-1:2], 2'b00};
          wdata_d = is_sw ? rs2v_q : '0;
        end else if (mem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = WB;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= RESET_PC;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == WB) begin
        pc_q <= npc_q;
        if (wb_en && (rd_idx != 5'd0)) regs_q[rd_idx] <= is_lw ? mdr_q : res_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == FETCH) && rd_q && mem_resp) ir_q <= mem_rdata;
    if (state_q == DECODE) begin
      rs1v_q <= regs_q[rs1_idx];
      rs2v_q <= regs_q[rs2_idx];
      imm_q  <= imm;
    end
    if (state_q == EXEC) begin
      res_q <= exec_res;
      npc_q <= exec_npc;
    end
    if ((state_q == MEM) && rd_q && mem_resp) mdr_q <= mem_rdata;
  end

  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_potato_core.sv
// Directed bench for potato_core: fixed-delay memory model, hand-computed program results.
module tb_potato_core;

  localparam int DELAY = 4;

  logic        clk, rst;
  logic [31:0] mem_rdata, mem_wdata, mem_addr;
  logic        mem_resp, mem_read, mem_write;

  logic [31:0] mem [128];
  logic [31:0] ra[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          cnt;
  bit          both_seen;
  int          total_cnt, pass_cnt;

  potato_core #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Memory: answers a held request after DELAY cycles with a one-cycle mem_resp
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    cnt       = 0;
    both_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_seen = 1'b1;
      if (rst) begin
        cnt = 0;
        mem_resp = 1'b0;
      end else if (mem_resp) begin
        mem_resp = 1'b0;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == DELAY) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            mem[mem_addr[8:2]] = mem_wdata;
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
          end else begin
            mem_rdata = mem[mem_addr[8:2]];
            ra.push_back(mem_addr);
          end
        end
      end
    end
  end

  logic [31:0] exp_wa [11] = '{32'h100, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h104,
                               32'h118, 32'h11C, 32'h120, 32'h128, 32'h12C};
  logic [31:0] exp_wd [11] = '{32'h5, 32'h14, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h5,
                               32'h0, 32'hF8000000, 32'h08000000, 32'h68, 32'h5};
  logic [31:0] exp_ra [30] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20,
                               32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h100, 32'h3C,
                               32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C,
                               32'h64, 32'h6C, 32'h70, 32'h74, 32'h78, 32'h78};

  initial begin
    int nread;
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0]  = enc_i(12'd9, 5'd0, 3'd0, 5'd1, 7'h13);          // ADDI x1,x0,9
    mem[1]  = enc_i(12'd4, 5'd0, 3'd0, 5'd2, 7'h13);          // ADDI x2,x0,4
    mem[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);           // SUB x3,x1,x2
    mem[3]  = enc_s(12'h100, 5'd3, 5'd0);                     // SW x3,0x100
    mem[4]  = enc_j(21'd8, 5'd6);                             // JAL x6,+8
    mem[5]  = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);          // skipped
    mem[6]  = enc_s(12'h108, 5'd6, 5'd0);                     // SW x6,0x108
    mem[7]  = enc_i(12'd1, 5'd0, 3'd0, 5'd8, 7'h13);          // ADDI x8,x0,1
    mem[8]  = enc_r(7'h20, 5'd8, 5'd0, 3'd0, 5'd9);           // SUB x9,x0,x8
    mem[9]  = enc_s(12'h10C, 5'd9, 5'd0);                     // SW x9,0x10C
    mem[10] = enc_r(7'h00, 5'd8, 5'd9, 3'd3, 5'd10);          // SLTU x10,x9,x8
    mem[11] = enc_r(7'h00, 5'd8, 5'd9, 3'd2, 5'd11);          // SLT x11,x9,x8
    mem[12] = enc_s(12'h110, 5'd10, 5'd0);
    mem[13] = enc_s(12'h114, 5'd11, 5'd0);
    mem[14] = enc_i(12'h100, 5'd0, 3'd2, 5'd5, 7'h03);        // LW x5,0x100
    mem[15] = enc_s(12'h104, 5'd5, 5'd0);
    mem[16] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);          // ADDI x0,x0,7
    mem[17] = enc_s(12'h118, 5'd0, 5'd0);
    mem[18] = {20'h80000, 5'd13, 7'h37};                      // LUI x13,0x80000
    mem[19] = enc_i(12'h404, 5'd13, 3'd5, 5'd12, 7'h13);      // SRAI x12,x13,4
    mem[20] = enc_i(12'h004, 5'd13, 3'd5, 5'd14, 7'h13);      // SRLI x14,x13,4
    mem[21] = enc_s(12'h11C, 5'd12, 5'd0);
    mem[22] = enc_s(12'h120, 5'd14, 5'd0);
    mem[23] = enc_b(13'd8, 5'd0, 5'd8, 3'd1);                 // BNE x8,x0,+8
    mem[24] = enc_s(12'h124, 5'd8, 5'd0);                     // skipped
    mem[25] = enc_i(12'h06D, 5'd0, 3'd0, 5'd16, 7'h67);       // JALR x16,0x6D(x0)
    mem[26] = enc_s(12'h124, 5'd8, 5'd0);                     // skipped
    mem[27] = enc_s(12'h128, 5'd16, 5'd0);
    mem[28] = enc_s(12'h12E, 5'd3, 5'd0);                     // misaligned -> 0x12C
    mem[29] = 32'h00000073;                                   // ECALL
    mem[30] = enc_b(13'd0, 5'd0, 5'd0, 3'd0);                 // BEQ self

    repeat (3) @(negedge clk);
    check("rst_read",  32'(mem_read), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);

    rst = 1'b0;
    for (int k = 0; k < 20 && !mem_read; k++) @(negedge clk);
    check("first_read",  32'(mem_read), 32'd1);
    check("first_addr",  mem_addr, 32'h0);
    check("first_write", 32'(mem_write), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_abort_read", 32'(mem_read), 32'd0);
    repeat (2) @(negedge clk);
    ra.delete();
    wa.delete();
    wd.delete();
    rst = 1'b0;
    for (int k = 0; k < 20 && !mem_read; k++) @(negedge clk);
    check("resume_read", 32'(mem_read), 32'd1);
    check("resume_addr", mem_addr, 32'h0);

    for (int k = 0; k < 5000 && wa.size() < 11; k++) @(negedge clk);
    check("wr_count", 32'(wa.size()), 32'd11);
    for (int i = 0; i < 11 && i < wa.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wa[i], exp_wa[i]);
      check($sformatf("wr_data%0d", i), wd[i], exp_wd[i]);
    end

`ifdef CORE_TRAP_HALT_EN
    nread = 28;
    for (int k = 0; k < 2000 && ra.size() < nread; k++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("halt_reads",  32'(ra.size()), 32'(nread));
    check("halt_writes", 32'(wa.size()), 32'd11);
    check("halt_read",   32'(mem_read), 32'd0);
`else
    nread = 30;
    for (int k = 0; k < 2000 && ra.size() < nread; k++) @(negedge clk);
    check("rd_count_min", 32'(ra.size() >= nread), 32'd1);
`endif
    for (int i = 0; i < nread && i < ra.size(); i++)
      check($sformatf("rd_addr%0d", i), ra[i], exp_ra[i]);

    check("rd_wr_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
